// File: rtl/music_pkg.sv
// music_pkg: track code constants and key-to-track mapping shared by the note-path blocks
package music_pkg;

    localparam int TRACK_W  = 6;
    localparam int NUM_KEYS = 16;

    localparam logic [TRACK_W-1:0] TRACK_REST = 6'd0;

    // Keys that have a sharp neighbour; the zero bits are the E/B style gaps in the scale
    localparam logic [NUM_KEYS-1:0] SHARP_MASK = 16'b1110_1101_1101_1011;

    // Natural track codes, element [15] (leftmost key) first
    localparam logic [NUM_KEYS-1:0][TRACK_W-1:0] NATURAL = '{
        6'd9,  6'd11, 6'd13, 6'd15, 6'd16, 6'd18, 6'd20, 6'd21,
        6'd23, 6'd25, 6'd27, 6'd28, 6'd30, 6'd32, 6'd33, 6'd35
    };

    typedef enum logic [1:0] {IDLE, PLAY, RETRIG} state_t;

    function automatic logic [TRACK_W-1:0] key_bit_to_track(input logic [3:0] idx);
        return NATURAL[idx];
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: 2-FF synchronizer plus a stability counter that commits a quiet input vector
module key_debouncer #(
    parameter int W       = 16,
    parameter int DEB_CNT = 1_000_000,
    parameter int CNT_W   = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] stable_vec
);

    logic [W-1:0]     sync1, sync2, samp;
    logic [CNT_W-1:0] cnt;
    logic             diff;

    assign diff = sync2 != samp;

    // Synchronize, restart the count on any change, saturate when quiet and commit as it reaches DEB_CNT-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= '0;
            sync2      <= '0;
            samp       <= '0;
            cnt        <= '0;
            stable_vec <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            samp  <= sync2;
            cnt   <= diff ? '0 : (cnt == CNT_W'(DEB_CNT - 1)) ? cnt : cnt + CNT_W'(1);
            if (!diff && cnt == CNT_W'(DEB_CNT - 2))
                stable_vec <= sync2;
        end
    end

endmodule

// File: rtl/key_encoder_one_track.sv
// key_encoder_one_track: debounced 16-key priority encoder to track code with note on/off pulses; SHARP_KEY_EN adds the sharp modifier
module key_encoder_one_track
    import music_pkg::*;
#(
    parameter int DEB_CNT = 1_000_000,
    parameter int CNT_W   = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key,
    input  logic                sharp,
    output logic [TRACK_W-1:0]  track,
    output logic                note_on,
    output logic                note_off,
    output logic                playing
);

`ifdef SHARP_KEY_EN
    localparam int W = NUM_KEYS + 1;
`else
    localparam int W = NUM_KEYS;
`endif

    logic [W-1:0]       raw, stable_vec;
    logic               sharp_s;
    logic [TRACK_W-1:0] enc;
    state_t             state;

`ifdef SHARP_KEY_EN
    assign raw     = {sharp, key};
    assign sharp_s = stable_vec[NUM_KEYS];
`else
    logic unused_sharp;
    assign raw          = key;
    assign sharp_s      = 1'b0;
    assign unused_sharp = sharp;
`endif

    key_debouncer #(.W(W), .DEB_CNT(DEB_CNT), .CNT_W(CNT_W)) u_deb (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (raw),
        .stable_vec (stable_vec)
    );

    // Priority encode: ascending scan so the highest pressed key overrides lower ones
    always_comb begin
        enc = TRACK_REST;
        for (int i = 0; i < NUM_KEYS; i++)
            if (stable_vec[i])
                enc = key_bit_to_track(4'(i)) + TRACK_W'(sharp_s && SHARP_MASK[i]);
    end

    // Note FSM; a changed code passes through one rest cycle so on/off never coincide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            track    <= TRACK_REST;
            note_on  <= 1'b0;
            note_off <= 1'b0;
            playing  <= 1'b0;
        end else begin
            note_on  <= 1'b0;
            note_off <= 1'b0;
            case (state)
                IDLE: if (enc != TRACK_REST) begin
                    state   <= PLAY;
                    track   <= enc;
                    note_on <= 1'b1;
                    playing <= 1'b1;
                end
                PLAY: if (enc != track) begin
                    state    <= (enc == TRACK_REST) ? IDLE : RETRIG;
                    track    <= TRACK_REST;
                    note_off <= 1'b1;
                    playing  <= 1'b0;
                end
                RETRIG: if (enc != TRACK_REST) begin
                    state   <= PLAY;
                    track   <= enc;
                    note_on <= 1'b1;
                    playing <= 1'b1;
                end else
                    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_encoder_one_track.sv
// tb_key_encoder_one_track: directed checks of debounce latency, priority, retrigger, sharp and reset behaviour
module tb_key_encoder_one_track;

`ifdef SHARP_KEY_EN
    localparam int SH = 1;
`else
    localparam int SH = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] key = 16'h8000;
    logic        sharp = 1'b0;
    logic [5:0]  track;
    logic        note_on, note_off, playing;

    int total = 0;
    int bad   = 0;
    int both  = 0;

    always #5 clk = ~clk;

    key_encoder_one_track #(.DEB_CNT(4), .CNT_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key      (key),
        .sharp    (sharp),
        .track    (track),
        .note_on  (note_on),
        .note_off (note_off),
        .playing  (playing)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Advance n clocks, counting pulses and the cycle of the first note_on (0 = none)
    task automatic run(input int n, output int first, output int ons, output int offs);
        first = 0;
        ons   = 0;
        offs  = 0;
        for (int c = 1; c <= n; c++) begin
            tick();
            if (note_on) begin
                ons++;
                if (first == 0) first = c;
            end
            if (note_off) offs++;
            if (note_on && note_off) both++;
        end
    endtask

    initial begin
        int f, on, off;
        repeat (3) tick();
        chk("rst_track", track, 0);
        chk("rst_note_on", note_on, 0);
        chk("rst_note_off", note_off, 0);
        chk("rst_playing", playing, 0);

        rst_n = 1'b1;
        run(12, f, on, off);
        chk("t1_latency", f, 7);
        chk("t1_ons", on, 1);
        chk("t1_offs", off, 0);
        chk("t1_track", track, 9);
        chk("t1_playing", playing, 1);
        key = 16'h0000;
        run(12, f, on, off);
        chk("t1_rel_offs", off, 1);
        chk("t1_rel_track", track, 0);

        key = 16'h2000;
        tick();
        key = 16'h0000;
        tick();
        key = 16'h2000;
        run(12, f, on, off);
        chk("t2_latency", f, 7);
        chk("t2_ons", on, 1);
        chk("t2_track", track, 13);

        key = 16'hA000;
        run(6, f, on, off);
        chk("t3_quiet_pulses", on + off, 0);
        chk("t3_quiet_track", track, 13);
        tick();
        chk("t3_off", note_off, 1);
        chk("t3_off_on", note_on, 0);
        chk("t3_rest_track", track, 0);
        chk("t3_rest_playing", playing, 0);
        tick();
        chk("t3_on", note_on, 1);
        chk("t3_on_off", note_off, 0);
        chk("t3_track", track, 9);
        chk("t3_playing", playing, 1);
        run(6, f, on, off);
        chk("t3_after_pulses", on + off, 0);

        key = 16'h2000;
        sharp = 1'b1;
        run(12, f, on, off);
        chk("t4_b13_track", track, 13 + SH);
        chk("t4_b13_ons", on, 1);
        chk("t4_b13_offs", off, 1);
        key = 16'h1000;
        run(12, f, on, off);
        chk("t4_b12_track", track, 15);
        chk("t4_b12_pulses", on + off, 2);
        sharp = 1'b0;
        run(12, f, on, off);
        chk("t4_b12_unsharp_pulses", on + off, 0);
        chk("t4_b12_unsharp_track", track, 15);

        key = 16'h0001;
        run(12, f, on, off);
        chk("t5_track", track, 35);
        key = 16'h0000;
        run(12, f, on, off);
        chk("t5_offs", off, 1);
        chk("t5_ons", on, 0);
        chk("t5_track_rest", track, 0);
        chk("t5_playing", playing, 0);
        run(10, f, on, off);
        chk("t5_idle_pulses", on + off, 0);

        key = 16'h0080;
        run(12, f, on, off);
        chk("t6_track", track, 23);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async_track", track, 0);
        chk("t6_async_playing", playing, 0);
        chk("t6_async_off", note_off, 0);
        run(2, f, on, off);
        chk("t6_rst_pulses", on + off, 0);
        rst_n = 1'b1;
        run(12, f, on, off);
        chk("t6_latency", f, 7);
        chk("t6_ons", on, 1);
        chk("t6_offs", off, 0);
        chk("t6_track_again", track, 23);

        chk("on_off_exclusive", both, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
